// File: rtl/byte_manip_pkg.sv
// Shared definitions for the byte-manipulation group:
// op codes, encoding prefixes and decoder FSM states.
package byte_manip_pkg;

  localparam logic [2:0] OP_MOVL  = 3'd0;
  localparam logic [2:0] OP_MOVLZ = 3'd1;
  localparam logic [2:0] OP_MOVLS = 3'd2;
  localparam logic [2:0] OP_MOVH  = 3'd3;
  localparam logic [2:0] OP_SWPB  = 3'd4;

  localparam logic [2:0]  MOV_PREFIX  = 3'b011;
  localparam logic [12:0] SWPB_PREFIX = 13'h09B0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_WAIT
  } state_t;

endpackage

// File: rtl/byte_instr_fields.sv
// Combinational field extraction for one instruction word.
// in: instr; out: legal, op, byte_imm, dst.
module byte_instr_fields
  import byte_manip_pkg::*;
(
  input  logic [15:0] instr,
  output logic        legal,
  output logic [2:0]  op,
  output logic [7:0]  byte_imm,
  output logic [2:0]  dst
);

  always_comb begin
    legal    = 1'b0;
    op       = OP_MOVL;
    byte_imm = 8'h00;
    dst      = instr[2:0];
    unique case (1'b1)
      (instr[15:13] == MOV_PREFIX): begin
        legal    = 1'b1;
        // [12:11] maps directly onto MOVL..MOVH
        op       = {1'b0, instr[12:11]};
        byte_imm = instr[10:3];
      end
      (instr[15:3] == SWPB_PREFIX): begin
        legal = 1'b1;
        op    = OP_SWPB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/byte_instr_decoder.sv
// Decoder/issuer for MOVL/MOVLZ/MOVLS/MOVH/SWPB.
// Ports: clk, rst_n, instr_valid/ready/instr in, exec_op/byte/dst/E
// out, exec_done in, illegal/timeout pulses, busy.
module byte_instr_decoder
  import byte_manip_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  exec_op,
  output logic [7:0]  exec_byte,
  output logic [2:0]  exec_dst,
  output logic        exec_E,
  input  logic        exec_done,
  output logic        illegal,
  output logic        timeout,
  output logic        busy
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  state_t state, state_nx;

  logic [15:0]   instr_q, instr_nx, dec_in;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    op_nx, dst_nx;
  logic [7:0]    byte_nx;
  logic          e_nx, ill_nx, to_nx;
  logic          accept;

  logic       f_legal;
  logic [2:0] f_op, f_dst;
  logic [7:0] f_byte;

  assign instr_ready = rst_n && (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign accept      = instr_valid && instr_ready;

  // In IDLE look at the incoming word so the illegal
  // flag can be registered on the accepting edge and
  // show up during the DECODE cycle.
  assign dec_in = (state == S_IDLE) ? instr : instr_q;

  byte_instr_fields u_fields (
    .instr    (dec_in),
    .legal    (f_legal),
    .op       (f_op),
    .byte_imm (f_byte),
    .dst      (f_dst)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    instr_nx = instr_q;
    op_nx    = exec_op;
    byte_nx  = exec_byte;
    dst_nx   = exec_dst;
    e_nx     = 1'b0;
    ill_nx   = 1'b0;
    to_nx    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          instr_nx = instr;
          ill_nx   = !f_legal;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (f_legal) begin
          op_nx    = f_op;
          byte_nx  = f_byte;
          dst_nx   = f_dst;
          e_nx     = 1'b1;
          state_nx = S_ISSUE;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (exec_done) begin
          state_nx = S_IDLE;
        end else begin
          cnt_nx   = '0;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (exec_done) begin
          state_nx = S_IDLE;
        end else begin
          if (cnt != TMAX) cnt_nx = cnt + 1'b1;
          if (TIMEOUT > 0 && cnt_nx == TMAX) begin
            to_nx    = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      instr_q   <= '0;
      exec_op   <= '0;
      exec_byte <= '0;
      exec_dst  <= '0;
      exec_E    <= 1'b0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      instr_q   <= instr_nx;
      exec_op   <= op_nx;
      exec_byte <= byte_nx;
      exec_dst  <= dst_nx;
      exec_E    <= e_nx;
      illegal   <= ill_nx;
      timeout   <= to_nx;
    end
  end

endmodule

// File: tb/tb_byte_instr_decoder.sv
// Self-checking bench for byte_instr_decoder.
// Directed steps plus a scoreboard checked on each exec_E.
module tb_byte_instr_decoder;
  import byte_manip_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  exec_op;
  logic [7:0]  exec_byte;
  logic [2:0]  exec_dst;
  logic        exec_E;
  logic        exec_done;
  logic        illegal;
  logic        timeout;
  logic        busy;

  byte_instr_decoder #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .exec_op     (exec_op),
    .exec_byte   (exec_byte),
    .exec_dst    (exec_dst),
    .exec_E      (exec_E),
    .exec_done   (exec_done),
    .illegal     (illegal),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] b;
    logic [2:0] dst;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_push = 0;
  int n_pulse = 0;
  int cyc = 0;
  int last_e = 0;
  int prev_e = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] o,
                      input logic [7:0] b,
                      input logic [2:0] d);
    exp_t e;
    e.op = o;
    e.b = b;
    e.dst = d;
    sb.push_back(e);
    n_push++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] w);
    instr_valid = 1'b1;
    instr = w;
    tick();
    instr_valid = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (exec_E === 1'b1) begin
      exp_t e;
      n_pulse++;
      prev_e = last_e;
      last_e = cyc;
      if (sb.size() == 0) begin
        chk("spurious_E", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("sb_op", 32'(exec_op), 32'(e.op));
        chk("sb_byte", 32'(exec_byte), 32'(e.b));
        chk("sb_dst", 32'(exec_dst), 32'(e.dst));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    exec_done = 1'b0;
    tick();
    tick();
    neg();
    chk("rst_ready", 32'(instr_ready), 0);
    chk("rst_E", 32'(exec_E), 0);
    chk("rst_op", 32'(exec_op), 0);
    chk("rst_byte", 32'(exec_byte), 0);
    chk("rst_dst", 32'(exec_dst), 0);
    chk("rst_ill", 32'(illegal), 0);
    chk("rst_to", 32'(timeout), 0);
    chk("rst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    neg();
    chk("ready_rel", 32'(instr_ready), 1);

    // MOVL, done together with issue
    exec_done = 1'b1;
    push(OP_MOVL, 8'h5A, 3'd3);
    send(16'h62D3);
    neg();
    chk("dec_busy", 32'(busy), 1);
    chk("dec_ready", 32'(instr_ready), 0);
    tick();
    neg();
    chk("movl_E", 32'(exec_E), 1);
    tick();
    neg();
    chk("movl_ready", 32'(instr_ready), 1);
    chk("movl_E_off", 32'(exec_E), 0);

    // MOVLZ then MOVH back-to-back
    push(OP_MOVLZ, 8'hFF, 3'd1);
    push(OP_MOVH, 8'h12, 3'd7);
    instr_valid = 1'b1;
    instr = 16'h6FF9;
    tick();
    instr = 16'h7897;
    tick();
    tick();
    tick();
    instr_valid = 1'b0;
    tick();
    neg();
    chk("b2b_E", 32'(exec_E), 1);
    tick();
    chk("b2b_gap", 32'(last_e - prev_e), 3);

    // SWPB then illegal word
    push(OP_SWPB, 8'h00, 3'd2);
    send(16'h4D82);
    tick();
    tick();
    send(16'h4D88);
    neg();
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_busy", 32'(busy), 1);
    tick();
    neg();
    chk("ill_off", 32'(illegal), 0);
    chk("ill_ready", 32'(instr_ready), 1);
    chk("ill_op", 32'(exec_op), 32'(OP_SWPB));
    chk("ill_byte", 32'(exec_byte), 0);
    chk("ill_dst", 32'(exec_dst), 2);

    // timeout with done held low
    exec_done = 1'b0;
    push(OP_MOVL, 8'h5A, 3'd3);
    send(16'h62D3);
    tick();
    for (int i = 0; i < 4; i++) tick();
    neg();
    chk("to_early", 32'(timeout), 0);
    chk("to_busy", 32'(busy), 1);
    tick();
    neg();
    chk("to_pulse", 32'(timeout), 1);
    chk("to_ready", 32'(instr_ready), 1);
    tick();
    neg();
    chk("to_off", 32'(timeout), 0);

    // done on the cycle the counter would hit 4
    push(OP_MOVH, 8'h12, 3'd7);
    send(16'h7897);
    tick();
    for (int i = 0; i < 4; i++) tick();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    neg();
    chk("tie_to", 32'(timeout), 0);
    chk("tie_ready", 32'(instr_ready), 1);
    chk("tie_busy", 32'(busy), 0);

    // reset during DECODE abandons the issue
    exec_done = 1'b1;
    send(16'h6FF9);
    rst_n = 1'b0;
    tick();
    neg();
    chk("mrst_E", 32'(exec_E), 0);
    chk("mrst_op", 32'(exec_op), 0);
    chk("mrst_byte", 32'(exec_byte), 0);
    chk("mrst_dst", 32'(exec_dst), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ready", 32'(instr_ready), 0);
    rst_n = 1'b1;
    tick();
    neg();
    chk("mrst_rel", 32'(instr_ready), 1);

    // valid held through WAIT with a second word
    exec_done = 1'b0;
    push(OP_MOVLZ, 8'hFF, 3'd1);
    push(OP_MOVL, 8'h5A, 3'd3);
    instr_valid = 1'b1;
    instr = 16'h6FF9;
    tick();
    instr = 16'h62D3;
    tick();
    tick();
    neg();
    chk("held_ready", 32'(instr_ready), 0);
    tick();
    exec_done = 1'b1;
    tick();
    neg();
    chk("held_acc", 32'(instr_ready), 1);
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    exec_done = 1'b0;
    neg();
    chk("held_idle", 32'(instr_ready), 1);
    tick();

    chk("pulse_cnt", 32'(n_pulse), 32'(n_push));
    chk("sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
